// File: rtl/key_debounce_irq_ctrl_if.sv
// ---------------------------------------------------------------------------
// key_debounce_irq_ctrl_if
//
// Avalon-MM slave port of the key conditioning block, bundled so the bus
// signals travel as one port.
//
// Signals
//   address     2   word address: 0 DATA, 1 IRQ_MASK, 2 reserved, 3 EDGE_CAPTURE
//   chipselect  1   slave select
//   write_n     1   active-low write strobe
//   writedata   32  write data
//   readdata    32  registered read data (one cycle after address)
//   irq         1   level interrupt, active-high
//
// Transfer semantics: there is no valid/ready pair on this bus. A write takes
// effect on every rising clk edge where chipselect=1 and write_n=0; it never
// stalls. A read needs no qualifier: readdata always shows, one cycle later,
// the register selected by address in the previous cycle.
//
// Modports
//   master  drives address/chipselect/write_n/writedata, observes readdata/irq
//   slave   the key controller side
// ---------------------------------------------------------------------------
interface key_debounce_irq_ctrl_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/key_debounce_irq_ctrl.sv
// ---------------------------------------------------------------------------
// key_debounce_irq_ctrl
//
// Conditions the board push-buttons before software sees them. For each key
// the raw asynchronous input is synchronised (2 flops), debounced by a
// stability counter, press (falling) edges of the debounced level are
// captured in EDGE_CAPTURE, and a maskable level interrupt is raised.
//
// Parameters
//   NKEYS            number of keys, 1..32
//   DEBOUNCE_CYCLES  cycles a new synchronised level must hold before it is
//                    accepted, >= 2
//   CNT_W            debounce counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous, active-low reset
//   key_in       in   raw buttons, active-low (0 = pressed)
//   bus          -    Avalon-MM slave (address, chipselect, write_n,
//                     writedata, readdata, irq)
//   dbg_pending  out  per-key debounce FSM state, 1 = PENDING, 0 = STABLE
//
// Register map (word addresses)
//   0 DATA          RO   {zeros, debounced level}
//   1 IRQ_MASK      RW   NKEYS bits, upper bits read 0
//   2 reserved      reads 0, writes ignored
//   3 EDGE_CAPTURE  R/W1C, a capture in the same cycle as a clear wins
// ---------------------------------------------------------------------------
module key_debounce_irq_ctrl #(
  parameter int NKEYS           = 2,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NKEYS-1:0]     key_in,
  key_debounce_irq_ctrl_if.slave bus,
  output logic [NKEYS-1:0]     dbg_pending
);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } key_state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_ECAP = 2'd3;

  // The cycle on which the FSM first sees sync != db (STABLE -> PENDING,
  // cnt <= 0) already counts as the first stable cycle of the new level.
  // Committing when cnt reaches DEBOUNCE_CYCLES-2 therefore moves db exactly
  // DEBOUNCE_CYCLES cycles after sync first differs, and cnt never goes
  // past DEBOUNCE_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  // -------------------------------------------------------------------------
  // Synchroniser: two flops per key, released level (1) out of reset.
  // -------------------------------------------------------------------------
  logic [NKEYS-1:0] sync1_q;
  logic [NKEYS-1:0] sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= key_in;
      sync2_q <= sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Per-key debounce FSM
  // -------------------------------------------------------------------------
  key_state_t       state_q [NKEYS];
  key_state_t       state_d [NKEYS];
  logic [CNT_W-1:0] cnt_q   [NKEYS];
  logic [CNT_W-1:0] cnt_d   [NKEYS];
  logic [NKEYS-1:0] db_q;
  logic [NKEYS-1:0] db_d;

  // State register (plus the counter and debounced level it controls)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NKEYS; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      db_q <= '1;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      db_q <= db_d;
    end
  end

  // Next-state logic
  always_comb begin
    for (int i = 0; i < NKEYS; i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        ST_STABLE: begin
          if (sync2_q[i] != db_q[i]) state_d[i] = ST_PENDING;
        end
        ST_PENDING: begin
          if (sync2_q[i] == db_q[i])  state_d[i] = ST_STABLE;
          else if (cnt_q[i] == CNT_LAST) state_d[i] = ST_STABLE;
        end
        default: state_d[i] = ST_STABLE;
      endcase
    end
  end

  // Output logic: counter, debounced level, debug state
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < NKEYS; i++) begin
      cnt_d[i]       = '0;
      dbg_pending[i] = (state_q[i] == ST_PENDING);
      if (state_q[i] == ST_PENDING) begin
        if (sync2_q[i] == db_q[i]) begin
          // Bounced back before acceptance: discard, db keeps its value.
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          db_d[i]  = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register file
  // -------------------------------------------------------------------------
  logic             wr_en;
  logic [NKEYS-1:0] wr_bits;
  logic [NKEYS-1:0] w1c_bits;
  logic [NKEYS-1:0] press;
  logic [NKEYS-1:0] mask_q;
  logic [NKEYS-1:0] ecap_q;
  logic [31:0]      rd_mux;
  logic [31:0]      readdata_q;
  logic             irq_q;
  logic             unused_wdata;

  assign wr_en    = bus.chipselect & ~bus.write_n;
  assign wr_bits  = bus.writedata[NKEYS-1:0];
  assign w1c_bits = (wr_en && (bus.address == ADDR_ECAP)) ? wr_bits : '0;

  // Press = debounced level about to fall this edge, so the capture bit sets
  // on the same edge db goes 1 -> 0.
  assign press = db_q & ~db_d;

  // Only the low NKEYS data bits are meaningful to any register.
  assign unused_wdata = ^bus.writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '0;
      ecap_q <= '0;
    end else begin
      if (wr_en && (bus.address == ADDR_MASK)) mask_q <= wr_bits;
      // Set is ORed in after the clear so a simultaneous capture wins.
      ecap_q <= (ecap_q & ~w1c_bits) | press;
    end
  end

  // Read mux uses the current register values, so a read in the same cycle
  // as a write returns the pre-write contents.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      ADDR_DATA: rd_mux = 32'(db_q);
      ADDR_MASK: rd_mux = 32'(mask_q);
      ADDR_ECAP: rd_mux = 32'(ecap_q);
      default:   rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      readdata_q <= rd_mux;
      irq_q      <= |(ecap_q & mask_q);
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_q;

endmodule
